// File: rtl/gen_scheduler.sv
// Game of Life generation sequencer: starts the cell-update engine, waits for it to
// finish, then flips the double-buffered field only during vertical blank.
module gen_scheduler #(
  parameter int ENG_TIMEOUT = 4096,
  parameter int GEN_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_go,
  input  logic                 i_pause,
  input  logic                 i_step,
  input  logic                 i_vblank,
  output logic                 o_eng_start,
  input  logic                 i_eng_done,
  output logic                 o_front_sel,
  output logic                 o_NFI_allowed,
  output logic                 o_busy,
  output logic [GEN_CNT_W-1:0] o_gen_cnt,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    WAIT_VB,
    SWAP
  } state_t;

  localparam int                CNT_W    = $clog2(ENG_TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(ENG_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             trigger;

  // A go request while paused is dropped, and a step while running is ignored.
  assign trigger = (i_go & ~i_pause) | (i_step & i_pause);

  // NOTE: every register here, including the engine watchdog counter, is reset
  // asynchronously so a reset in any state abandons the generation without a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      o_eng_start <= 1'b0;
      o_front_sel <= 1'b0;
      o_gen_cnt   <= '0;
      o_timeout   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the
      // pre-edge value of state and counters.
      o_eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state       <= START;
            o_eng_start <= 1'b1;
          end
        end

        START: begin
          state   <= COMPUTE;
          tmo_cnt <= '0;
        end

        COMPUTE: begin
          // Done on the final watchdog cycle takes priority over the timeout.
          if (i_eng_done) begin
            state <= WAIT_VB;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            o_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        WAIT_VB: begin
          if (i_vblank) begin
            state <= SWAP;
          end
        end

        SWAP: begin
          state       <= IDLE;
          o_front_sel <= ~o_front_sel;
          o_gen_cnt   <= o_gen_cnt + GEN_CNT_W'(1);
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_NFI_allowed = (state == IDLE);
  assign o_busy        = ~o_NFI_allowed;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: a default-parameter instance plus a small
// instance (ENG_TIMEOUT=16, GEN_CNT_W=2) for the watchdog and counter wrap.
module tb_gen_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic go = 1'b0, pause = 1'b0, step = 1'b0, vblank = 1'b0, done = 1'b0;

  logic        a_eng_start, a_front_sel, a_allowed, a_busy, a_timeout;
  logic [15:0] a_gen_cnt;
  logic        b_eng_start, b_front_sel, b_allowed, b_busy, b_timeout;
  logic [1:0]  b_gen_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gen_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_pause(pause), .i_step(step),
    .i_vblank(vblank), .o_eng_start(a_eng_start), .i_eng_done(done),
    .o_front_sel(a_front_sel), .o_NFI_allowed(a_allowed), .o_busy(a_busy),
    .o_gen_cnt(a_gen_cnt), .o_timeout(a_timeout)
  );

  gen_scheduler #(.ENG_TIMEOUT(16), .GEN_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_pause(pause), .i_step(step),
    .i_vblank(vblank), .o_eng_start(b_eng_start), .i_eng_done(done),
    .o_front_sel(b_front_sel), .o_NFI_allowed(b_allowed), .o_busy(b_busy),
    .o_gen_cnt(b_gen_cnt), .o_timeout(b_timeout)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    go = 1'b0; pause = 1'b0; step = 1'b0; done = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // Fast generation: go, d extra COMPUTE cycles, done; returns on the first IDLE cycle.
  task automatic run_gen(input int d);
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(1 + d);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(1);
    total++; if (a_allowed !== 1'b1) begin bad++; $display("FAIL reset_allowed got=%b exp=1", a_allowed); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    total++; if (a_eng_start !== 1'b0) begin bad++; $display("FAIL reset_eng_start got=%b exp=0", a_eng_start); end
    total++; if ({a_front_sel, a_timeout, a_gen_cnt} !== 18'h0) begin bad++; $display("FAIL reset_regs got=%b/%b/%0h exp=0/0/0", a_front_sel, a_timeout, a_gen_cnt); end
    rst_n = 1'b1;
    cyc(1);
    // Stray done and vblank in IDLE must be ignored.
    vblank = 1'b1; done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(3);
    total++; if ({a_allowed, a_front_sel, a_gen_cnt} !== {1'b1, 1'b0, 16'h0}) begin bad++; $display("FAIL idle_stray_done got=%b/%b/%0h exp=1/0/0", a_allowed, a_front_sel, a_gen_cnt); end
  endtask

  task automatic test_basic();
    int err;
    do_reset();
    vblank = 1'b1;
    go = 1'b1;
    cyc(1);  // cycle 11: START
    go = 1'b0;
    total++; if (a_eng_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", a_eng_start); end
    total++; if (a_allowed !== 1'b0 || a_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=allowed %b busy %b exp=0/1", a_allowed, a_busy); end
    err = 0;
    for (int i = 0; i < 19; i++) begin  // cycles 12..30
      cyc(1);
      if (a_eng_start !== 1'b0 || a_allowed !== 1'b0) err++;
    end
    total++; if (err !== 0) begin bad++; $display("FAIL basic_compute_window got=%0d bad cycles exp=0", err); end
    done = 1'b1;
    cyc(1);  // cycle 31: WAIT_VB
    done = 1'b0;
    cyc(1);  // cycle 32: SWAP
    total++; if (a_front_sel !== 1'b0 || a_allowed !== 1'b0) begin bad++; $display("FAIL basic_swap_cycle got=front %b allowed %b exp=0/0", a_front_sel, a_allowed); end
    cyc(1);  // cycle 33
    total++; if (a_front_sel !== 1'b1) begin bad++; $display("FAIL basic_front got=%b exp=1", a_front_sel); end
    total++; if (a_gen_cnt !== 16'd1) begin bad++; $display("FAIL basic_gen_cnt got=%0d exp=1", a_gen_cnt); end
    total++; if (a_allowed !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=allowed %b busy %b exp=1/0", a_allowed, a_busy); end
  endtask

  task automatic test_vblank_wait();
    int err;
    do_reset();
    vblank = 1'b0;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(1);
    done = 1'b1;
    cyc(1);  // WAIT_VB
    done = 1'b0;
    err = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_front_sel !== 1'b0 || a_busy !== 1'b1 || a_gen_cnt !== 16'd0) err++;
      cyc(1);
    end
    total++; if (err !== 0) begin bad++; $display("FAIL vb_hold got=%0d bad cycles exp=0", err); end
    vblank = 1'b1;
    cyc(1);  // SWAP
    total++; if (a_front_sel !== 1'b0 || a_busy !== 1'b1) begin bad++; $display("FAIL vb_swap_cycle got=front %b busy %b exp=0/1", a_front_sel, a_busy); end
    cyc(1);
    total++; if ({a_front_sel, a_gen_cnt, a_busy} !== {1'b1, 16'd1, 1'b0}) begin bad++; $display("FAIL vb_after got=%b/%0d/%b exp=1/1/0", a_front_sel, a_gen_cnt, a_busy); end
  endtask

  task automatic test_pause_step();
    int starts;
    do_reset();
    vblank = 1'b1;
    pause = 1'b1;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      go = 1'b1;
      cyc(1);
      go = 1'b0;
      if (a_eng_start === 1'b1) starts++;
      cyc(1);
      if (a_eng_start === 1'b1) starts++;
    end
    total++; if (starts !== 0 || a_allowed !== 1'b1) begin bad++; $display("FAIL pause_go got=%0d starts allowed %b exp=0/1", starts, a_allowed); end
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    total++; if (a_eng_start !== 1'b1) begin bad++; $display("FAIL step_start got=%b exp=1", a_eng_start); end
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(2);
    total++; if (a_gen_cnt !== 16'd1 || a_front_sel !== 1'b1) begin bad++; $display("FAIL step_gen got=%0d/%b exp=1/1", a_gen_cnt, a_front_sel); end
    pause = 1'b0;
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_eng_start === 1'b1 || a_allowed !== 1'b1) starts++;
      cyc(1);
    end
    total++; if (starts !== 0 || a_gen_cnt !== 16'd1) begin bad++; $display("FAIL step_unpaused got=%0d bad cycles gen %0d exp=0/1", starts, a_gen_cnt); end
  endtask

  task automatic test_timeout();
    int err;
    do_reset();
    vblank = 1'b1;
    // Done on the 16th COMPUTE cycle wins over the watchdog.
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(16);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    total++; if (b_allowed !== 1'b0 || b_timeout !== 1'b0) begin bad++; $display("FAIL tmo_edge_done got=allowed %b tmo %b exp=0/0", b_allowed, b_timeout); end
    cyc(2);
    total++; if (b_gen_cnt !== 2'd1 || b_timeout !== 1'b0) begin bad++; $display("FAIL tmo_edge_gen got=%0d tmo %b exp=1/0", b_gen_cnt, b_timeout); end
    // Engine hangs: COMPUTE lasts 16 cycles, then IDLE with the flag set.
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    err = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (b_allowed !== 1'b0 || b_timeout !== 1'b0) err++;
    end
    total++; if (err !== 0) begin bad++; $display("FAIL tmo_compute_len got=%0d bad cycles exp=0", err); end
    cyc(1);
    total++; if (b_timeout !== 1'b1 || b_allowed !== 1'b1) begin bad++; $display("FAIL tmo_flag got=tmo %b allowed %b exp=1/1", b_timeout, b_allowed); end
    total++; if (b_front_sel !== 1'b1 || b_gen_cnt !== 2'd1) begin bad++; $display("FAIL tmo_no_swap got=%b/%0d exp=1/1", b_front_sel, b_gen_cnt); end
    run_gen(3);
    total++; if ({b_front_sel, b_gen_cnt, b_timeout} !== {1'b0, 2'd2, 1'b1}) begin bad++; $display("FAIL tmo_sticky got=%b/%0d/%b exp=0/2/1", b_front_sel, b_gen_cnt, b_timeout); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    vblank = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_gen(0);
      total++; if (b_gen_cnt !== exp_seq[k]) begin bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", k, b_gen_cnt, exp_seq[k]); end
    end
    total++; if (b_front_sel !== 1'b0) begin bad++; $display("FAIL wrap_front got=%b exp=0", b_front_sel); end
    total++; if (a_gen_cnt !== 16'd4) begin bad++; $display("FAIL wide_cnt got=%0d exp=4", a_gen_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vblank = 1'b1;
    run_gen(0);
    // Reset during START, asserted between edges.
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (a_eng_start !== 1'b0 || a_allowed !== 1'b1) begin bad++; $display("FAIL rst_start got=start %b allowed %b exp=0/1", a_eng_start, a_allowed); end
    @(negedge clk);
    rst_n = 1'b1;
    run_gen(0);
    // Reset during COMPUTE.
    vblank = 1'b0;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(1);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({a_allowed, a_busy, a_front_sel, a_gen_cnt} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin bad++; $display("FAIL rst_compute got=%b/%b/%b/%0d exp=1/0/0/0", a_allowed, a_busy, a_front_sel, a_gen_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(4);
    total++; if ({a_allowed, a_front_sel, a_gen_cnt} !== {1'b1, 1'b0, 16'd0}) begin bad++; $display("FAIL rst_late_done got=%b/%b/%0d exp=1/0/0", a_allowed, a_front_sel, a_gen_cnt); end
    // Reset during WAIT_VB.
    vblank = 1'b1;
    run_gen(0);
    vblank = 1'b0;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    total++; if (a_allowed !== 1'b0 || a_front_sel !== 1'b1) begin bad++; $display("FAIL rst_pre_wait got=%b/%b exp=0/1", a_allowed, a_front_sel); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({a_allowed, a_front_sel, a_gen_cnt, a_timeout} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin bad++; $display("FAIL rst_waitvb got=%b/%b/%0d/%b exp=1/0/0/0", a_allowed, a_front_sel, a_gen_cnt, a_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    vblank = 1'b1;
    cyc(4);
    total++; if ({a_allowed, a_front_sel, a_gen_cnt} !== {1'b1, 1'b0, 16'd0}) begin bad++; $display("FAIL rst_late_vblank got=%b/%b/%0d exp=1/0/0", a_allowed, a_front_sel, a_gen_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_vblank_wait();
    test_pause_step();
    test_timeout();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_scheduler.md
# gen_scheduler

Sequences one Game of Life generation over the double-buffered field memory. It accepts a trigger (the `o_go` pulse from the next-field-iteration controller, or a single-step request while paused) and starts the cell-update engine. It waits for the engine to finish, then swaps front and back buffers only during display vertical blank, so the display never shows a half-written field. It sits between `NFI_controller`, the cell-update engine and the VGA scanout.

## Interface
- `ENG_TIMEOUT`, default 4096: maximum cycles spent in COMPUTE before the engine is declared hung; must be ≥ 2.
- `GEN_CNT_W`, default 16: width of the generation counter.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_go`  in  1  single-cycle generation request, from `NFI_controller` `o_go`.
- `i_pause`  in  1  level; when high, `i_go` is ignored and only `i_step` triggers.
- `i_step`  in  1  single-cycle pulse; triggers one generation while paused.
- `i_vblank`  in  1  level from scanout, high during vertical blank.
- `o_eng_start`  out  1  single-cycle engine start pulse; the engine reads buffer `o_front_sel` and writes buffer `~o_front_sel`.
- `i_eng_done`  in  1  single-cycle engine completion pulse.
- `o_front_sel`  out  1  buffer index currently displayed and read by the engine.
- `o_NFI_allowed`  out  1  scheduler idle; feeds `NFI_controller` `i_NFI_allowed`.
- `o_busy`  out  1  inverse of `o_NFI_allowed`.
- `o_gen_cnt`  out  GEN_CNT_W  number of completed generations, modulo 2^GEN_CNT_W.
- `o_timeout`  out  1  sticky engine-hang flag.

## Operation
- FSM states: IDLE, START, COMPUTE, WAIT_VB, SWAP. All state transitions are registered.
- IDLE: the trigger is `(i_go & ~i_pause) | (i_step & i_pause)`. On trigger, go to START.
  - `i_go` while paused is dropped, not queued.
  - `i_step` while not paused is ignored.
- START: lasts one cycle; `o_eng_start` = 1. Go to COMPUTE and clear the timeout counter.
- COMPUTE:
  - On `i_eng_done`, go to WAIT_VB.
  - Otherwise the counter increments each cycle.
  - If the counter equals ENG_TIMEOUT-1 and `i_eng_done` = 0, set `o_timeout` and return to IDLE with no swap and no count.
  - `i_eng_done` on the final count cycle wins; no timeout is raised.
- WAIT_VB: when `i_vblank` = 1, go to SWAP. This includes the case where vblank is already high on entry.
- SWAP: lasts one cycle. Toggle `o_front_sel` and increment `o_gen_cnt` (wrapping from all-ones to 0). Go to IDLE.
- `o_NFI_allowed` = (state == IDLE). It is a pure state decode, independent of `i_pause`. `o_busy` = ~`o_NFI_allowed`.
- `o_eng_start` is a registered output, high exactly while the state is START.
- Inputs outside their listed states are ignored: `i_eng_done` outside COMPUTE, `i_vblank` outside WAIT_VB, and triggers outside IDLE.
- `o_timeout` clears only on reset.
- Reset, asynchronous, any state: state = IDLE, `o_eng_start` = 0, `o_front_sel` = 0, `o_gen_cnt` = 0, `o_timeout` = 0, timeout counter = 0.
  - `o_NFI_allowed` = 1 and `o_busy` = 0 while in reset.
  - Reset mid-COMPUTE abandons the generation; the buffer is not swapped.

## Timing
- Trigger sampled at edge T: state = START and `o_eng_start` = 1 during cycle T+1. `o_NFI_allowed` falls at T+1.
- `i_eng_done` sampled at edge D in COMPUTE: WAIT_VB during D+1.
- First edge V ≥ D+1 with `i_vblank` = 1 in WAIT_VB: SWAP during V+1. New `o_front_sel`, `o_gen_cnt` and `o_NFI_allowed` = 1 all appear at V+2.
- Minimum trigger-to-idle time is 5 cycles: done arrives on the first COMPUTE cycle and vblank is already high.
- Timeout: COMPUTE lasts exactly ENG_TIMEOUT cycles. `o_timeout` = 1 and IDLE take effect on the cycle after the last COMPUTE cycle.
- A trigger is accepted on the first IDLE cycle after SWAP. Back-to-back generations are supported.

## Test plan
- Basic generation: reset, `i_vblank` = 1, `i_go` pulse at cycle 10, `i_eng_done` at cycle 30 → one-cycle `o_eng_start` at 11; `o_front_sel` 0→1 and `o_gen_cnt` = 1 at 33; `o_NFI_allowed` low from 11 to 32.
- Vblank wait: done with `i_vblank` = 0, vblank rises 50 cycles later → no swap before the vblank edge; swap visible exactly 2 cycles after vblank is sampled; `o_busy` high throughout.
- Pause/step: `i_pause` = 1 with 5 `i_go` pulses → no `o_eng_start`. One `i_step` → exactly one generation, `o_gen_cnt` +1. `i_step` with `i_pause` = 0 → ignored.
- Timeout: ENG_TIMEOUT = 16, never assert done → `o_timeout` = 1 and IDLE after 16 COMPUTE cycles; `o_front_sel` and `o_gen_cnt` unchanged. A following generation completes normally and `o_timeout` stays 1. Done on the 16th cycle → no timeout.
- Wrap: GEN_CNT_W = 2, four generations → `o_gen_cnt` sequence 1, 2, 3, 0; `o_front_sel` back to 0.
- Reset mid-COMPUTE and mid-WAIT_VB: assert `rst_n` = 0 asynchronously → all outputs at reset values immediately. A later `i_eng_done` with no trigger → no effect.
